ov7670_grid_sampler: RTL and testbench



---
 rtl/ov7670_pkg.sv | 41 ++++
 rtl/ov7670_pixel_position.sv | 108 ++++++++++
 rtl/ov7670_grid_sampler.sv | 152 +++++++++++++++
 tb/tb_ov7670_grid_sampler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 grid sampler.
// The optional luma-only mode is selected with OV7670_LUMA_ONLY_EN.
package ov7670_pkg;

   localparam logic [3:0] DB_IDLE  = 4'd0;
   localparam logic [3:0] DB_START = 4'd1;
   localparam logic [3:0] DB_WAIT  = 4'd2;
   localparam logic [3:0] DB_STORE = 4'd3;
   localparam logic [3:0] DB_DONE  = 4'd4;
   localparam logic [3:0] DB_ERR   = 4'd5;

   typedef enum logic [3:0] {
      ST_IDLE  = DB_IDLE,
      ST_START = DB_START,
      ST_WAIT  = DB_WAIT,
      ST_STORE = DB_STORE,
      ST_DONE  = DB_DONE,
      ST_ERR   = DB_ERR
   } state_t;

   function automatic int calc_qw(input int img_w, input int grid_cols);
      return img_w / grid_cols;
   endfunction

   function automatic int calc_qh(input int img_h, input int grid_rows);
      return img_h / grid_rows;
   endfunction

   function automatic int calc_num_cells(input int grid_rows, input int grid_cols);
      return grid_rows * grid_cols;
   endfunction

   function automatic int calc_frame_bytes(input int img_w, input int img_h, input int bpp);
      return img_w * img_h * bpp;
   endfunction

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/ov7670_pixel_position.sv
// Raster position tracker: byte/column/row counters plus per-cell offsets,
// flagging bytes that fall on a cell's centre pixel.
module ov7670_pixel_position
   import ov7670_pkg::*;
#(
   parameter int IMG_W     = 160,
   parameter int IMG_H     = 120,
   parameter int BPP       = 2,
   parameter int GRID_ROWS = 3,
   parameter int GRID_COLS = 3,
   parameter int CIW       = clog2_min1(calc_num_cells(GRID_ROWS, GRID_COLS)),
   parameter int BW        = clog2_min1(BPP)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clear,
   input  logic           advance,
   output logic           hit,
   output logic [CIW-1:0] cell_idx,
   output logic [BW-1:0]  byte_idx,
   output logic           last_byte
);

   localparam int QW  = calc_qw(IMG_W, GRID_COLS);
   localparam int QH  = calc_qh(IMG_H, GRID_ROWS);
   localparam int CW  = clog2_min1(IMG_W);
   localparam int RW  = clog2_min1(IMG_H);
   localparam int QCW = clog2_min1(QW);
   localparam int QRW = clog2_min1(QH);
   localparam int GCW = $clog2(GRID_COLS + 1);
   localparam int GRW = $clog2(GRID_ROWS + 1);

   localparam logic [BW-1:0]  BYTE_LAST = BW'(BPP - 1);
   localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [QCW-1:0] QW_LAST   = QCW'(QW - 1);
   localparam logic [QRW-1:0] QH_LAST   = QRW'(QH - 1);
   localparam logic [QCW-1:0] QW_MID    = QCW'(QW / 2);
   localparam logic [QRW-1:0] QH_MID    = QRW'(QH / 2);
   localparam logic [GCW-1:0] GC_END    = GCW'(GRID_COLS);
   localparam logic [GRW-1:0] GR_END    = GRW'(GRID_ROWS);

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [QCW-1:0] col_in_cell;
   logic [QRW-1:0] row_in_cell;
   logic [GCW-1:0] cell_col;
   logic [GRW-1:0] cell_row;

   // Cell trackers saturate at GRID_* so remainder pixels past the last cell never hit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_idx    <= '0;
         col         <= '0;
         row         <= '0;
         col_in_cell <= '0;
         row_in_cell <= '0;
         cell_col    <= '0;
         cell_row    <= '0;
      end else if (clear) begin
         byte_idx    <= '0;
         col         <= '0;
         row         <= '0;
         col_in_cell <= '0;
         row_in_cell <= '0;
         cell_col    <= '0;
         cell_row    <= '0;
      end else if (advance) begin
         if (byte_idx != BYTE_LAST) begin
            byte_idx <= byte_idx + 1'b1;
         end else begin
            byte_idx <= '0;
            if (col != COL_LAST) begin
               col <= col + 1'b1;
               if (col_in_cell == QW_LAST) begin
                  col_in_cell <= '0;
                  if (cell_col != GC_END) cell_col <= cell_col + 1'b1;
               end else begin
                  col_in_cell <= col_in_cell + 1'b1;
               end
            end else begin
               col         <= '0;
               col_in_cell <= '0;
               cell_col    <= '0;
               if (row != ROW_LAST) begin
                  row <= row + 1'b1;
                  if (row_in_cell == QH_LAST) begin
                     row_in_cell <= '0;
                     if (cell_row != GR_END) cell_row <= cell_row + 1'b1;
                  end else begin
                     row_in_cell <= row_in_cell + 1'b1;
                  end
               end else begin
                  row         <= '0;
                  row_in_cell <= '0;
                  cell_row    <= '0;
               end
            end
         end
      end
   end

   assign hit = (cell_col != GC_END) && (cell_row != GR_END) &&
                (col_in_cell == QW_MID) && (row_in_cell == QH_MID);
   assign cell_idx  = CIW'(int'(cell_row) * GRID_COLS + int'(cell_col));
   assign last_byte = (byte_idx == BYTE_LAST) && (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/ov7670_grid_sampler.sv
// OV7670 grid sampler: captures one frame, writes each grid cell's centre pixel
// to the sample RAM. Define OV7670_LUMA_ONLY_EN to store only the Y byte.
module ov7670_grid_sampler
   import ov7670_pkg::*;
#(
   parameter int IMG_W       = 160,
   parameter int IMG_H       = 120,
   parameter int BPP         = 2,
   parameter int GRID_ROWS   = 3,
   parameter int GRID_COLS   = 3,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   output logic              partida_serial,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              we_byte,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              ocupado,
   output logic              pronto,
   output logic              erro_timeout,
   output logic [3:0]        db_estado
);

   localparam int CIW = clog2_min1(calc_num_cells(GRID_ROWS, GRID_COLS));
   localparam int BW  = clog2_min1(BPP);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t            state, state_next;
   logic [TW-1:0]     to_cnt;
   logic [7:0]        data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              last_q;
   logic              accept;
   logic              clear;
   logic              hit;
   logic              hit_sel;
   logic              last_byte;
   logic [CIW-1:0]    cell_idx;
   logic [BW-1:0]     byte_idx;
   logic [ADDR_W-1:0] addr_calc;

   ov7670_pixel_position #(
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H),
      .BPP       (BPP),
      .GRID_ROWS (GRID_ROWS),
      .GRID_COLS (GRID_COLS),
      .CIW       (CIW),
      .BW        (BW)
   ) u_pos (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .advance   (accept),
      .hit       (hit),
      .cell_idx  (cell_idx),
      .byte_idx  (byte_idx),
      .last_byte (last_byte)
   );

`ifdef OV7670_LUMA_ONLY_EN
   assign hit_sel   = hit && (byte_idx == '0);
   assign addr_calc = ADDR_W'(cell_idx);
`else
   assign hit_sel   = hit;
   assign addr_calc = ADDR_W'(int'(cell_idx) * BPP + int'(byte_idx));
`endif

   // Abort also withholds ready so no byte is consumed on the aborting cycle.
   assign byte_ready = (state == ST_WAIT) && !abortar;
   assign accept     = byte_valid && byte_ready;
   assign clear      = (state == ST_START);
   assign ocupado    = (state != ST_IDLE);
   assign db_estado  = state;
   assign wr_addr    = addr_q;
   assign wr_data    = data_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                               to_cnt <= '0;
      else if ((state == ST_START) || accept)  to_cnt <= '0;
      else if (state == ST_WAIT)               to_cnt <= to_cnt + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         addr_q <= '0;
         last_q <= 1'b0;
      end else if (accept && hit_sel) begin
         data_q <= byte_data;
         addr_q <= addr_calc;
         last_q <= last_byte;
      end
   end

   always_comb begin
      state_next     = state;
      partida_serial = 1'b0;
      we_byte        = 1'b0;
      pronto         = 1'b0;
      erro_timeout   = 1'b0;
      case (state)
         ST_IDLE:  if (iniciar) state_next = ST_START;
         ST_START: begin
            partida_serial = 1'b1;
            state_next     = ST_WAIT;
         end
         ST_WAIT: begin
            if (accept) begin
               if (hit_sel)        state_next = ST_STORE;
               else if (last_byte) state_next = ST_DONE;
            end else if (to_cnt == TO_LAST) begin
               state_next = ST_ERR;
            end
         end
         ST_STORE: begin
            we_byte    = 1'b1;
            state_next = last_q ? ST_DONE : ST_WAIT;
         end
         ST_DONE: begin
            pronto     = 1'b1;
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            erro_timeout = 1'b1;
            state_next   = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (abortar) begin
         state_next     = ST_IDLE;
         partida_serial = 1'b0;
         we_byte        = 1'b0;
         pronto         = 1'b0;
         erro_timeout   = 1'b0;
      end
   end

endmodule

// File: tb/tb_ov7670_grid_sampler.sv
// Scoreboard bench for ov7670_grid_sampler on a 6x6, 2-byte, 3x3 configuration.
module tb_ov7670_grid_sampler;

   localparam int IMG_W = 6;
   localparam int IMG_H = 6;
   localparam int BPP = 2;
   localparam int GR = 3;
   localparam int GC = 3;
   localparam int ADDR_W = 8;
   localparam int TO_CYC = 50;
   localparam int FB = IMG_W * IMG_H * BPP;
   localparam int QW = IMG_W / GC;
   localparam int QH = IMG_H / GR;
`ifdef OV7670_LUMA_ONLY_EN
   localparam int PRONTO_DELTA = 2;
`else
   localparam int PRONTO_DELTA = 1;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic iniciar = 1'b0;
   logic abortar = 1'b0;
   logic byte_valid = 1'b0;
   logic [7:0] byte_data = '0;
   logic partida_serial, byte_ready, we_byte, ocupado, pronto, erro_timeout;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] db_estado;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int pronto_cnt = 0;
   int erro_cnt = 0;
   int partida_cnt = 0;
   int pronto_cyc = 0;
   int last_we_cyc = 0;
   wr_t exp_q[$];
   logic [7:0] frame_data [FB];

   always #5 clock = ~clock;

   ov7670_grid_sampler #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .BPP         (BPP),
      .GRID_ROWS   (GR),
      .GRID_COLS   (GC),
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .iniciar        (iniciar),
      .abortar        (abortar),
      .partida_serial (partida_serial),
      .byte_valid     (byte_valid),
      .byte_data      (byte_data),
      .byte_ready     (byte_ready),
      .we_byte        (we_byte),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .ocupado        (ocupado),
      .pronto         (pronto),
      .erro_timeout   (erro_timeout),
      .db_estado      (db_estado)
   );

   // Reference: which frame byte lands in the sample RAM, and where.
   function automatic bit model_hit(input int i, output int addr);
      int p, b, r, c, rr, cc;
      p = i / BPP;
      b = i % BPP;
      r = p / IMG_W;
      c = p % IMG_W;
      rr = r / QH;
      cc = c / QW;
      addr = 0;
      if (rr >= GR || cc >= GC) return 0;
      if (r != rr * QH + QH / 2 || c != cc * QW + QW / 2) return 0;
`ifdef OV7670_LUMA_ONLY_EN
      if (b != 0) return 0;
      addr = rr * GC + cc;
`else
      addr = (rr * GC + cc) * BPP + b;
`endif
      return 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every write strobe, tallies pulses.
   initial begin
      wr_t e;
      forever begin
         @(negedge clock);
         cyc++;
         if (we_byte) begin
            tests++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: addr %0d data %0d, none expected", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data) begin
                  fails++;
                  $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                           wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
         if (pronto) begin
            pronto_cnt++;
            pronto_cyc = cyc;
         end
         if (erro_timeout) erro_cnt++;
         if (partida_serial) partida_cnt++;
      end
   end

   task automatic clear_counts();
      pronto_cnt = 0;
      erro_cnt = 0;
      partida_cnt = 0;
   endtask

   task automatic start_frame();
      @(posedge clock); #1 iniciar = 1'b1;
      @(posedge clock); #1 iniciar = 1'b0;
   endtask

   task automatic send_bytes(input int first, input int last, input int max_gap);
      for (int i = first; i <= last; i++) begin
         int n, a, gap;
         byte_valid = 1'b1;
         byte_data = frame_data[i];
         n = 0;
         while (1) begin
            @(negedge clock);
            if (byte_ready) break;
            n++;
            if (n > 200) begin
               tests++;
               fails++;
               $display("FAIL handshake: byte %0d not accepted, got no ready expected ready", i);
               byte_valid = 1'b0;
               return;
            end
         end
         if (model_hit(i, a)) exp_q.push_back({a[ADDR_W-1:0], frame_data[i]});
         @(posedge clock); #1 byte_valid = 1'b0;
         gap = $urandom_range(max_gap, 0);
         repeat (gap) begin
            @(posedge clock); #1;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (ocupado && n < 100);
      chk("idle_reached", int'(ocupado), 0);
   endtask

   task automatic run_frame(input int max_gap, input bit rand_data, input bit pulse_start);
      for (int i = 0; i < FB; i++) frame_data[i] = rand_data ? 8'($urandom) : 8'(i);
      clear_counts();
      start_frame();
      if (pulse_start) begin
         fork
            send_bytes(0, FB - 1, max_gap);
            begin
               repeat (8) begin
                  repeat (5) @(posedge clock);
                  #1 iniciar = 1'b1;
                  @(posedge clock); #1 iniciar = 1'b0;
               end
            end
         join
      end else begin
         send_bytes(0, FB - 1, max_gap);
      end
      wait_idle();
      chk("frame_pronto_count", pronto_cnt, 1);
      chk("frame_erro_count", erro_cnt, 0);
      chk("frame_partida_count", partida_cnt, 1);
      chk("frame_pending_writes", exp_q.size(), 0);
      if (max_gap == 0) chk("pronto_after_last_write", pronto_cyc - last_we_cyc, PRONTO_DELTA);
   endtask

   initial begin
      #2;
      chk("reset_we", int'(we_byte), 0);
      chk("reset_pronto", int'(pronto), 0);
      chk("reset_ocupado", int'(ocupado), 0);
      chk("reset_ready", int'(byte_ready), 0);
      chk("reset_estado", int'(db_estado), 0);
      chk("reset_addr", int'(wr_addr), 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Ordered frame, data = index, valid every cycle.
      run_frame(0, 1'b0, 1'b0);
      // Randomised data and handshake gaps.
      run_frame(4, 1'b1, 1'b0);
      run_frame(2, 1'b1, 1'b0);

      // Stall after byte 20 until the timeout fires.
      for (int i = 0; i < FB; i++) frame_data[i] = 8'(i);
      clear_counts();
      start_frame();
      send_bytes(0, 20, 0);
      repeat (60) @(posedge clock);
      @(negedge clock);
      chk("timeout_erro_count", erro_cnt, 1);
      chk("timeout_pronto_count", pronto_cnt, 0);
      chk("timeout_estado", int'(db_estado), 0);
      chk("timeout_pending_writes", exp_q.size(), 0);

      // Abort while byte 14 sits in STORE: its write must vanish.
      clear_counts();
      start_frame();
      send_bytes(0, 14, 0);
      abortar = 1'b1;
      void'(exp_q.pop_back());
      @(posedge clock); #1 abortar = 1'b0;
      chk("abort_ocupado", int'(ocupado), 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("abort_pronto_count", pronto_cnt, 0);
      chk("abort_erro_count", erro_cnt, 0);
      chk("abort_pending_writes", exp_q.size(), 0);
      run_frame(0, 1'b0, 1'b0);

      // Repeated iniciar mid-frame must not restart the transfer.
      run_frame(0, 1'b0, 1'b1);

      // Asynchronous reset partway through a frame.
      for (int i = 0; i < FB; i++) frame_data[i] = 8'($urandom);
      start_frame();
      send_bytes(0, 39, 1);
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midreset_estado", int'(db_estado), 0);
      chk("midreset_ready", int'(byte_ready), 0);
      chk("midreset_we", int'(we_byte), 0);
      chk("midreset_addr", int'(wr_addr), 0);
      chk("midreset_data", int'(wr_data), 0);
      chk("midreset_ocupado", int'(ocupado), 0);
      exp_q.delete();
      @(posedge clock); #1 reset = 1'b0;
      run_frame(0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
